// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths and write-port source encoding for the register-file writeback arbiter.
package wb_port_arbiter_pkg;

  localparam int unsigned DEF_DSIZE = 32;
  localparam int unsigned DEF_ASIZE = 5;

  typedef enum logic [1:0] {
    WB_SRC_NONE = 2'd0,
    WB_SRC_PIPE = 2'd1,
    WB_SRC_BUF  = 2'd2
  } wb_src_e;

endpackage

// File: rtl/wb_pend_fifo.sv
// Pending-result FIFO for multi-cycle writebacks: storage, pointers, count,
// kill-by-address and address lookups for hazard detection.
module wb_pend_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned DSIZE = DEF_DSIZE,
  parameter int unsigned ASIZE = DEF_ASIZE,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [ASIZE-1:0] push_addr,
  input  logic [DSIZE-1:0] push_data,
  input  logic             pop,
  input  logic             kill,
  input  logic [ASIZE-1:0] kill_addr,
  input  logic [ASIZE-1:0] look1,
  input  logic [ASIZE-1:0] look2,
  output logic             full,
  output logic             empty,
  output logic             head_valid,
  output logic [ASIZE-1:0] head_addr,
  output logic [DSIZE-1:0] head_data,
  output logic             hit1,
  output logic             hit2
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DEPTH-1:0] valid;
  logic [ASIZE-1:0] addr_q [DEPTH];
  logic [DSIZE-1:0] data_q [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;

  // Kill first, then pop/push, so an entry written this cycle keeps its valid bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++)
        if (kill && addr_q[i] == kill_addr) valid[i] <= 1'b0;
      if (pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + 1'b1;
      end
      if (push) begin
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= push_addr;
      data_q[wr_ptr] <= push_data;
    end
  end

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign head_valid = valid[rd_ptr];
  assign head_addr  = addr_q[rd_ptr];
  assign head_data  = data_q[rd_ptr];

  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid[i] && addr_q[i] == look1) hit1 = 1'b1;
      if (valid[i] && addr_q[i] == look2) hit2 = 1'b1;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, buffered
// multi-cycle results drain when idle or when their age forces a stall.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned DSIZE    = DEF_DSIZE,
  parameter int unsigned ASIZE    = DEF_ASIZE,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_wen,
  input  logic [ASIZE-1:0] wb_waddr,
  input  logic [DSIZE-1:0] wb_wdata,
  input  logic             mu_valid,
  input  logic [ASIZE-1:0] mu_waddr,
  input  logic [DSIZE-1:0] mu_wdata,
  output logic             mu_ready,
  output logic             rf_wen,
  output logic [ASIZE-1:0] rf_waddr,
  output logic [DSIZE-1:0] rf_wdata,
  output logic             stall_pipe,
  input  logic [ASIZE-1:0] raddr1,
  input  logic [ASIZE-1:0] raddr2,
  output logic             pend_hit1,
  output logic             pend_hit2
);

  localparam int unsigned AW = $clog2(MAX_WAIT + 1);

  logic             full, empty, head_valid, hit1, hit2;
  logic [ASIZE-1:0] head_addr;
  logic [DSIZE-1:0] head_data;
  logic             push, store, pop, kill;
  logic             pipe_req, head_req, drain;
  logic [AW-1:0]    age;
  wb_src_e          sel;

  assign mu_ready = !full && !rst;
  assign push     = mu_valid && mu_ready;
  assign store    = push && (mu_waddr != '0);
  assign pipe_req = wb_wen && (wb_waddr != '0);
  assign head_req = !empty;
  assign drain    = (age >= AW'(MAX_WAIT));

  always_comb begin
    sel        = WB_SRC_NONE;
    stall_pipe = 1'b0;
    if (!rst) begin
      if (drain && head_req) begin
        sel        = WB_SRC_BUF;
        stall_pipe = pipe_req;
      end else if (pipe_req) begin
        sel = WB_SRC_PIPE;
      end else if (head_req) begin
        sel = WB_SRC_BUF;
      end
    end
  end

  assign pop  = (sel == WB_SRC_BUF);
  assign kill = (sel == WB_SRC_PIPE);

  always_ff @(posedge clk) begin
    if (rst || pop || empty) age <= '0;
    else if (!drain)         age <= age + 1'b1;
  end

  always_comb begin
    rf_wen   = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    case (sel)
      WB_SRC_PIPE: begin
        rf_wen   = 1'b1;
        rf_waddr = wb_waddr;
        rf_wdata = wb_wdata;
      end
      WB_SRC_BUF: begin
        rf_wen   = head_valid;
        rf_waddr = head_addr;
        rf_wdata = head_data;
      end
      default: ;
    endcase
  end

  // Lookups also see the result being pushed this cycle, ahead of its storage.
  assign pend_hit1 = !rst && (raddr1 != '0) && (hit1 || (push && mu_waddr == raddr1));
  assign pend_hit2 = !rst && (raddr2 != '0) && (hit2 || (push && mu_waddr == raddr2));

  wb_pend_fifo #(
    .DSIZE(DSIZE),
    .ASIZE(ASIZE),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (store),
    .push_addr (mu_waddr),
    .push_data (mu_wdata),
    .pop       (pop),
    .kill      (kill),
    .kill_addr (wb_waddr),
    .look1     (raddr1),
    .look2     (raddr2),
    .full      (full),
    .empty     (empty),
    .head_valid(head_valid),
    .head_addr (head_addr),
    .head_data (head_data),
    .hit1      (hit1),
    .hit2      (hit2)
  );

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with hand-computed expectations.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_wen;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        mu_valid;
  logic [4:0]  mu_waddr;
  logic [31:0] mu_wdata;
  logic        mu_ready;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall_pipe;
  logic [4:0]  raddr1, raddr2;
  logic        pend_hit1, pend_hit2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(
    .DSIZE(32),
    .ASIZE(5),
    .DEPTH(2),
    .MAX_WAIT(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wb_wen    (wb_wen),
    .wb_waddr  (wb_waddr),
    .wb_wdata  (wb_wdata),
    .mu_valid  (mu_valid),
    .mu_waddr  (mu_waddr),
    .mu_wdata  (mu_wdata),
    .mu_ready  (mu_ready),
    .rf_wen    (rf_wen),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .stall_pipe(stall_pipe),
    .raddr1    (raddr1),
    .raddr2    (raddr2),
    .pend_hit1 (pend_hit1),
    .pend_hit2 (pend_hit2)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs settle 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_wen = 0; wb_waddr = 0; wb_wdata = 0;
    mu_valid = 0; mu_waddr = 0; mu_wdata = 0;
    raddr1 = 0; raddr2 = 0;
  endtask

  task automatic mu_push(input logic [4:0] a, input logic [31:0] d);
    mu_valid = 1; mu_waddr = a; mu_wdata = d;
  endtask

  task automatic pipe_wr(input logic [4:0] a, input logic [31:0] d);
    wb_wen = 1; wb_waddr = a; wb_wdata = d;
  endtask

  initial begin
    idle();
    rst = 1;
    mu_push(5'd2, 32'h1);
    raddr1 = 5'd2;
    step(); step();
    check_eq("rst_rf_wen", rf_wen, 0);
    check_eq("rst_mu_ready", mu_ready, 0);
    check_eq("rst_stall", stall_pipe, 0);
    check_eq("rst_hit1", pend_hit1, 0);
    rst = 0;
    idle();
    step();
    check_eq("post_rst_rf_wen", rf_wen, 0);
    check_eq("post_rst_ready", mu_ready, 1);

    // 1: idle pipe, single push drains next cycle
    mu_push(5'd3, 32'hAAAA0001);
    #1 check_eq("t1_push_rf_wen", rf_wen, 0);
    step();
    idle(); raddr1 = 5'd3;
    #1;
    check_eq("t1_rf_wen", rf_wen, 1);
    check_eq("t1_waddr", rf_waddr, 3);
    check_eq("t1_wdata", rf_wdata, 32'hAAAA0001);
    check_eq("t1_hit_before_pop", pend_hit1, 1);
    step();
    check_eq("t1_empty_rf_wen", rf_wen, 0);
    check_eq("t1_hit_after", pend_hit1, 0);

    // 2: continuous pipe writes, forced drains every MAX_WAIT
    pipe_wr(5'd1, 32'h100);
    mu_push(5'd4, 32'h44);
    #1;
    check_eq("t2_c0_waddr", rf_waddr, 1);
    check_eq("t2_c0_ready", mu_ready, 1);
    step();
    mu_push(5'd5, 32'h55);
    #1;
    check_eq("t2_c1_waddr", rf_waddr, 1);
    check_eq("t2_c1_ready", mu_ready, 1);
    step();
    mu_push(5'd6, 32'h66);
    #1;
    check_eq("t2_c2_ready_full", mu_ready, 0);
    step();
    mu_valid = 0;
    for (int i = 3; i <= 4; i++) begin
      #1;
      check_eq("t2_wait_waddr", rf_waddr, 1);
      check_eq("t2_wait_stall", stall_pipe, 0);
      step();
    end
    #1;
    check_eq("t2_drain1_stall", stall_pipe, 1);
    check_eq("t2_drain1_waddr", rf_waddr, 4);
    check_eq("t2_drain1_wdata", rf_wdata, 32'h44);
    check_eq("t2_drain1_ready", mu_ready, 0);
    step();
    for (int i = 6; i <= 9; i++) begin
      #1;
      check_eq("t2_wait2_waddr", rf_waddr, 1);
      check_eq("t2_wait2_stall", stall_pipe, 0);
      step();
    end
    #1;
    check_eq("t2_drain2_stall", stall_pipe, 1);
    check_eq("t2_drain2_waddr", rf_waddr, 5);
    check_eq("t2_drain2_wdata", rf_wdata, 32'h55);
    step();
    #1;
    check_eq("t2_after_waddr", rf_waddr, 1);
    check_eq("t2_after_ready", mu_ready, 1);
    idle();
    step();
    check_eq("t2_idle_rf_wen", rf_wen, 0);

    // 3: WAW kill of a buffered entry
    mu_push(5'd7, 32'h11); raddr1 = 5'd7;
    #1 check_eq("t3_push_hit", pend_hit1, 1);
    step();
    mu_valid = 0;
    pipe_wr(5'd7, 32'h22);
    #1;
    check_eq("t3_pipe_waddr", rf_waddr, 7);
    check_eq("t3_pipe_wdata", rf_wdata, 32'h22);
    check_eq("t3_hit_during", pend_hit1, 1);
    step();
    wb_wen = 0;
    #1;
    check_eq("t3_killed_rf_wen", rf_wen, 0);
    check_eq("t3_hit_after", pend_hit1, 0);
    step();
    check_eq("t3_empty_rf_wen", rf_wen, 0);

    // 4: pipe write to r0 and push to r0
    idle();
    mu_push(5'd9, 32'h99);
    step();
    mu_valid = 0;
    pipe_wr(5'd0, 32'hDEAD);
    #1;
    check_eq("t4_rf_wen", rf_wen, 1);
    check_eq("t4_waddr", rf_waddr, 9);
    check_eq("t4_wdata", rf_wdata, 32'h99);
    check_eq("t4_stall", stall_pipe, 0);
    step();
    check_eq("t4_r0_rf_wen", rf_wen, 0);
    wb_wen = 0;
    mu_push(5'd0, 32'h1234);
    #1 check_eq("t4_r0_push_ready", mu_ready, 1);
    step();
    mu_valid = 0;
    #1 check_eq("t4_r0_push_no_wr", rf_wen, 0);
    step();
    check_eq("t4_r0_push_no_wr2", rf_wen, 0);

    // 5: reset with a full buffer
    pipe_wr(5'd1, 32'h100);
    mu_push(5'd10, 32'hA);
    step();
    mu_push(5'd11, 32'hB);
    step();
    mu_valid = 0;
    #1 check_eq("t5_full_ready", mu_ready, 0);
    rst = 1; mu_push(5'd12, 32'hC); raddr1 = 5'd10;
    #1;
    check_eq("t5_rst_rf_wen", rf_wen, 0);
    check_eq("t5_rst_ready", mu_ready, 0);
    check_eq("t5_rst_stall", stall_pipe, 0);
    check_eq("t5_rst_hit", pend_hit1, 0);
    step();
    check_eq("t5_rst2_ready", mu_ready, 0);
    check_eq("t5_rst2_rf_wen", rf_wen, 0);
    rst = 0;
    idle(); raddr1 = 5'd10; raddr2 = 5'd11;
    #1;
    check_eq("t5_post_ready", mu_ready, 1);
    check_eq("t5_post_hit1", pend_hit1, 0);
    check_eq("t5_post_hit2", pend_hit2, 0);
    for (int i = 0; i < 6; i++) begin
      check_eq("t5_no_stale", rf_wen, 0);
      step();
    end

    // 6: same-cycle push hit; raddr 0 never hits
    idle();
    raddr1 = 5'd5; raddr2 = 5'd0;
    mu_push(5'd5, 32'h5);
    #1;
    check_eq("t6_hit1_push", pend_hit1, 1);
    check_eq("t6_hit2_zero", pend_hit2, 0);
    mu_waddr = 5'd0;
    #1 check_eq("t6_hit2_r0_push", pend_hit2, 0);
    mu_waddr = 5'd5;
    step();
    mu_valid = 0; raddr2 = 5'd5;
    #1;
    check_eq("t6_stored_hit1", pend_hit1, 1);
    check_eq("t6_stored_hit2", pend_hit2, 1);
    check_eq("t6_drain_waddr", rf_waddr, 5);
    step();
    check_eq("t6_after_hit1", pend_hit1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two sources: the in-order pipeline writeback coming out of the MEM/WB stage (after the memtoreg mux), and a multi-cycle unit (mul/div) whose results complete out of band.
- Pipeline writes have priority. Multi-cycle results wait in a small pending buffer.
- An age counter forces a drain cycle so buffered results are never starved. Pending-address hit outputs let hazard logic stall dependent reads.

Parameters:
- DSIZE, `DSIZE (32): data width.
- ASIZE, `ASIZE (5): register address width.
- DEPTH, 2: pending buffer entries (power of 2, ≥2).
- MAX_WAIT, 4: cycles the head entry may wait before a forced drain.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- wb_wen  in  1  pipeline writeback enable (MEM/WB wen_out)
- wb_waddr  in  ASIZE  pipeline writeback address
- wb_wdata  in  DSIZE  pipeline writeback data (post memtoreg mux)
- mu_valid  in  1  multi-cycle result valid
- mu_waddr  in  ASIZE  multi-cycle destination
- mu_wdata  in  DSIZE  multi-cycle result
- mu_ready  out  1  buffer can accept this cycle
- rf_wen  out  1  register-file write enable
- rf_waddr  out  ASIZE  register-file write address
- rf_wdata  out  DSIZE  register-file write data
- stall_pipe  out  1  pipeline must hold MEM/WB this cycle; its write is not performed
- raddr1  in  ASIZE  decode read address 1
- raddr2  in  ASIZE  decode read address 2
- pend_hit1  out  1  raddr1 has a pending buffered write
- pend_hit2  out  1  raddr2 has a pending buffered write

Behaviour:

Reset and push:
- Reset is synchronous, active-high on clk. It empties the buffer, clears all valid bits and clears age.
- While rst is high: rf_wen=0, mu_ready=0, stall_pipe=0, pend_hit1/2=0.
- The buffer is a FIFO of {valid, waddr, wdata}.
- mu_ready = !full, combinational from the count.
- Push occurs when mu_valid && mu_ready.
- A push with mu_waddr==0 is accepted (handshake completes) but not stored.

Source definitions:
- pipe_req = wb_wen && wb_waddr!=0. Writes to r0 are never issued.
- head_req = !empty.
- drain = (age >= MAX_WAIT); age is a registered counter.

Port selection (combinational, zero added latency):
- If drain && head_req: the port serves the buffer head and pops it. stall_pipe = pipe_req.
- Else if pipe_req: the port serves the pipeline, and the buffer holds.
- Else if head_req: the port serves the buffer head and pops it.
- Else: rf_wen=0.
- A head with valid=0 (killed) pops without asserting rf_wen. That cycle still counts as serving the head.

Age counter:
- Clears to 0 on a pop or when the buffer is empty.
- Otherwise increments, saturating at MAX_WAIT.

WAW and kill rules:
- A performed pipeline write clears valid on every stored entry whose waddr matches; the pipeline write is program-order newer.
- An entry pushed in the same cycle is not killed.

Pending hits:
- pend_hit1/2 = raddrN != 0 && (a stored valid entry matches, or a push this cycle matches).
- Combinational.

Simultaneous events and boundaries:
- Push and pop in the same cycle are both allowed. When full, push is refused (mu_ready=0), even if a pop occurs that cycle.
- Pointers wrap modulo DEPTH.
- A pipeline write that is stalled is retried by the pipeline on the next cycle.
- At most one forced drain is taken per age expiry. After a pop, age restarts at 0.

Decomposition:
- define.v supplies DSIZE and ASIZE.
- Add to define.v the source-select constants WB_SRC_NONE=0, WB_SRC_PIPE=1, WB_SRC_BUF=2 (2 bits).
- One sub-module, wb_pend_fifo, contains storage, pointers, count, the kill-by-address operation, and the address-match ports for the pend_hit lookups.
- The top level contains the arbitration, the age counter and the output muxing.

Test Plan:
1. Idle pipeline; mu push r3=0xAAAA0001 → rf_wen=1, waddr=3, data=0xAAAA0001 one cycle after the push. Buffer then empty, pend_hit for r3 is 0 afterwards.
2. Continuous pipe writes to r1, with mu pushes r4 and r5 → both buffered; the third push sees mu_ready=0. After 4 waiting cycles: stall_pipe=1, r4 is written; then age restarts and r5 is drained after 4 more cycles.
3. Buffered r7=0x11 followed by pipe write r7=0x22 → entry killed; r7 is never written with 0x11; pend_hit(r7) falls to 0 after the pipe write.
4. Pipe write r0 with a buffer entry pending → rf_wen is driven by the buffer head; r0 is never written. A mu push to r0 is accepted and produces no write.
5. Buffer full, then rst asserted mid-operation → next cycle buffer empty, rf_wen=0, mu_ready=0 while rst=1. No stale entry writes after rst deasserts.
6. raddr1=5 in the same cycle as mu push r5 → pend_hit1=1 that cycle. raddr2=0 → pend_hit2=0 always.
